// File: rtl/mem_miss_ctrl.sv
// Miss sequencer for the L1/L2 write-back, write-allocate data cache: one outstanding miss.
// Define MISS_PERF_CNT_EN to add the 32-bit miss and stall performance counters.
module mem_miss_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int L2_LATENCY  = 1,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  l1_hit,
  input  logic                  l1_victim_dirty,
  input  logic [ADDR_WIDTH-1:0] l1_victim_addr,
  input  logic                  l2_hit,
  input  logic                  l2_victim_dirty,
  input  logic [ADDR_WIDTH-1:0] l2_victim_addr,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  l1_wb_en,
  output logic                  l2_lookup,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  l2_fill,
  output logic                  l1_fill,
  output logic                  fill_we,
  output logic                  busy,
`ifdef MISS_PERF_CNT_EN
  output logic [31:0]           perf_l1_miss,
  output logic [31:0]           perf_l2_miss,
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic [2:0]            dbg_state
);

  localparam int MAX_LAT = (L2_LATENCY > MEM_LATENCY) ? L2_LATENCY : MEM_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] L2_INIT  = CW'(L2_LATENCY - 1);
  localparam logic [CW-1:0] MEM_INIT = CW'(MEM_LATENCY - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] L1_WB   = 3'd1;
  localparam logic [2:0] L2_LOOK = 3'd2;
  localparam logic [2:0] L2_WB   = 3'd3;
  localparam logic [2:0] MEM_RD  = 3'd4;
  localparam logic [2:0] L2_FILL = 3'd5;
  localparam logic [2:0] L1_FILL = 3'd6;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  miss;
  logic                  cnt_zero;

  assign miss     = (state == IDLE) & req_valid & ~l1_hit;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      miss_addr <= '0;
      we_q      <= 1'b0;
      wb_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr <= req_addr;
            we_q      <= req_we;
            if (l1_victim_dirty) begin
              state <= L1_WB;
            end else begin
              state <= L2_LOOK;
              cnt   <= L2_INIT;
            end
          end
        end
        L1_WB: begin
          state <= L2_LOOK;
          cnt   <= L2_INIT;
        end
        L2_LOOK: begin
          // L2 hit/victim status is only trusted on the final lookup cycle.
          if (cnt_zero) begin
            if (l2_hit) begin
              state <= L1_FILL;
            end else begin
              cnt <= MEM_INIT;
              if (l2_victim_dirty) begin
                state   <= L2_WB;
                wb_addr <= l2_victim_addr;
              end else begin
                state <= MEM_RD;
              end
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        L2_WB: begin
          if (cnt_zero) begin
            state <= MEM_RD;
            cnt   <= MEM_INIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        MEM_RD: begin
          if (cnt_zero) state <= L2_FILL;
          else          cnt   <= cnt - CW'(1);
        end
        L2_FILL: state <= L1_FILL;
        L1_FILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall     = busy | miss;
  assign l1_wb_en  = (state == L1_WB);
  assign l2_lookup = (state == L2_LOOK);
  assign mem_wr_en = (state == L2_WB);
  assign mem_rd_en = (state == MEM_RD);
  assign l2_fill   = (state == L2_FILL);
  assign l1_fill   = (state == L1_FILL);
  assign fill_we   = l1_fill & we_q;
  assign mem_addr  = mem_wr_en ? wb_addr : (mem_rd_en ? miss_addr : '0);
  assign dbg_state = state;

`ifdef MISS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_l1_miss      <= '0;
      perf_l2_miss      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (miss) perf_l1_miss <= perf_l1_miss + 32'd1;
      if (l2_lookup & cnt_zero & ~l2_hit) perf_l2_miss <= perf_l2_miss + 32'd1;
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  // The victim address is consumed by the cache arrays, not the sequencer.
  logic unused_ok;
  assign unused_ok = ^l1_victim_addr;

endmodule

// File: doc/mem_miss_ctrl.md
Name: mem_miss_ctrl

Overview:
- Miss-handling sequencer for the two-level data cache (L1 set-associative, L2 set-associative) in the memory stage.
- On an L1 miss it stalls the pipeline, writes back dirty victims and looks up L2. On an L2 miss it fetches from main data memory, then refills L2 and L1 and releases the stall so the access replays and hits.
- Write-allocate, write-back policy. One outstanding miss at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- L2_LATENCY, 1, cycles per L2 tag/data lookup; must be ≥1.
- MEM_LATENCY, 4, cycles per main-memory word read or write; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  M-stage load or store present.
- req_we  in  1  the request is a store.
- req_addr  in  ADDR_WIDTH  M-stage address (ALU result).
- l1_hit  in  1  L1 hit for req_addr.
- l1_victim_dirty  in  1  L1 victim line dirty.
- l1_victim_addr  in  ADDR_WIDTH  L1 victim address.
- l2_hit  in  1  L2 hit; valid on the last L2_LOOK cycle.
- l2_victim_dirty  in  1  L2 victim dirty; valid on the last L2_LOOK cycle.
- l2_victim_addr  in  ADDR_WIDTH  L2 victim address.
- stall  out  1  freeze the pipeline.
- miss_addr  out  ADDR_WIDTH  latched miss address.
- l1_wb_en  out  1  write the L1 victim into L2.
- l2_lookup  out  1  L2 lookup in progress.
- mem_rd_en  out  1  main-memory read.
- mem_wr_en  out  1  main-memory write (L2 victim).
- mem_addr  out  ADDR_WIDTH  main-memory address.
- l2_fill  out  1  one-cycle L2 refill strobe.
- l1_fill  out  1  one-cycle L1 refill strobe.
- fill_we  out  1  merge the store data during l1_fill (latched req_we).
- busy  out  1  state ≠ IDLE.

Behaviour:
- States: IDLE, L1_WB, L2_LOOK, L2_WB, MEM_RD, L2_FILL, L1_FILL. There is a single down-counter cnt, wide enough for max(L2_LATENCY, MEM_LATENCY).
- Reset: state=IDLE, cnt=0, miss_addr=0, latched we=0. All strobes, stall and busy are 0 the cycle after rst is sampled. Reset mid-miss aborts immediately; no strobe completes.
- stall = busy | (state==IDLE & req_valid & ~l1_hit). It is combinational, so the miss cycle itself stalls.
- IDLE:
  - req_valid & l1_hit, or ~req_valid: stay in IDLE.
  - Miss: latch req_addr→miss_addr and req_we. Go to L1_WB if l1_victim_dirty, else go to L2_LOOK with cnt=L2_LATENCY-1.
- L1_WB: l1_wb_en=1 for exactly 1 cycle, then L2_LOOK with cnt=L2_LATENCY-1.
- L2_LOOK: l2_lookup=1 while cnt counts down. At cnt==0:
  - l2_hit → L1_FILL.
  - l2_victim_dirty → L2_WB with cnt=MEM_LATENCY-1.
  - otherwise → MEM_RD with cnt=MEM_LATENCY-1.
- L2_WB: mem_wr_en=1, mem_addr=l2_victim_addr for MEM_LATENCY cycles, then MEM_RD with cnt reloaded.
- MEM_RD: mem_rd_en=1, mem_addr=miss_addr for MEM_LATENCY cycles, then L2_FILL.
- L2_FILL: l2_fill=1 for 1 cycle, then L1_FILL.
- L1_FILL: l1_fill=1 for 1 cycle, fill_we = latched we; then IDLE. The replayed access must hit.
- mem_addr=0 outside L2_WB and MEM_RD. Strobes are mutually exclusive, one-hot by state.
- Requests and inputs that change while busy are ignored; only the latched values are used.
- Stall cycles, including the miss cycle:
  - L2 hit, clean: 2+L2_LATENCY.
  - Add 1 if the L1 victim is dirty.
  - L2 miss: add MEM_LATENCY+1; add a further MEM_LATENCY if the L2 victim is dirty.
- A back-to-back miss in the cycle after returning to IDLE starts a new sequence with no bubble.

Optional Feature:
- MISS_PERF_CNT_EN defined: adds outputs perf_l1_miss, perf_l2_miss and perf_stall_cycles, each 32-bit.
  - perf_l1_miss increments on each IDLE miss.
  - perf_l2_miss increments on each L2_LOOK exit without l2_hit.
  - perf_stall_cycles increments on each cycle stall=1.
  - All counters wrap at 2^32 and are cleared by rst.
- Undefined: none of these ports or registers exist.

Test Plan:
- Defaults; req_valid=1, l1_hit=1 for 10 cycles → stall=0 and busy=0 throughout, no strobes.
- L1 miss, clean victim, l2_hit=1, addr 0x104 → stall high for 3 cycles, l2_lookup for 1 cycle, l1_fill in cycle 3, miss_addr=0x104, then stall=0.
- L1 dirty victim, L2 miss with clean victim → stall 1+1+1+4+1+1=9 cycles. Strobe order: l1_wb_en, l2_lookup, mem_rd_en×4 with mem_addr=miss_addr, l2_fill, l1_fill.
- L2 miss with dirty victim at 0x2000, store request → mem_wr_en×4 at 0x2000 before mem_rd_en×4; fill_we=1 on l1_fill; 13 stall cycles.
- rst asserted during the 2nd MEM_RD cycle → next cycle IDLE, all outputs 0, no l2_fill/l1_fill; a new miss afterwards sequences normally.
- MISS_PERF_CNT_EN defined, run the previous three scenarios → perf_l1_miss=3, perf_l2_miss=2, perf_stall_cycles=25.
